// File: rtl/ddr_arb_pkg.sv
// rtl/ddr_arb_pkg.sv - shared widths, IDs and FSM state type for ddr_axi_arbiter
package ddr_arb_pkg;

  localparam int ADDR_W = 28;
  localparam int DATA_W = 256;
  localparam int STRB_W = 32;
  localparam int LEN_W  = 4;
  localparam int ID_W   = 4;

  localparam logic [ID_W-1:0] RD_ID = 4'hF;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_ADDR = 3'd1,
    WR_DATA = 3'd2,
    RD_ADDR = 3'd3,
    RD_DATA = 3'd4
  } arb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - N-way round-robin picker; pointer moves past the winner when advance is high
module rr_arbiter #(
  parameter int N     = 2,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req,
  input  logic             advance,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] idx
);

  logic [IDX_W-1:0] ptr;
  logic [N-1:0]     rot;
  logic             found;
  int               sel;

  // Rotate so bit 0 is the requester at the pointer, then take the first set bit.
  always_comb begin
    rot   = N'({req, req} >> ptr);
    found = 1'b0;
    sel   = int'(ptr);
    for (int k = 0; k < N; k++) begin
      if (!found && rot[k]) begin
        found = 1'b1;
        sel   = int'(ptr) + k;
      end
    end
    if (sel >= N) sel = sel - N;
    idx = IDX_W'(sel);
    gnt = found ? (N'(1) << idx) : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (advance && found) begin
      ptr <= (int'(idx) == N - 1) ? '0 : idx + 1'b1;
    end
  end

endmodule

// File: rtl/ddr_axi_arbiter.sv
// rtl/ddr_axi_arbiter.sv - one-burst-at-a-time scheduler of N_WR writers and one reader onto the ddr3_32 AXI port
// Optional watchdog that abandons a stalled burst: define DDR_ARB_WDOG_EN.
module ddr_axi_arbiter
  import ddr_arb_pkg::*;
#(
  parameter int N_WR       = 2,
  parameter int RD_MAX     = 4,
  parameter int WDOG_TICKS = 4096
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        ddr_inited,

  input  logic [N_WR-1:0]             wr_req,
  input  logic [N_WR-1:0][ADDR_W-1:0] wr_addr,
  input  logic [N_WR-1:0][LEN_W-1:0]  wr_len,
  input  logic [N_WR-1:0][DATA_W-1:0] wr_data,
  input  logic [N_WR-1:0][STRB_W-1:0] wr_strb,
  output logic [N_WR-1:0]             wr_gnt,
  output logic [N_WR-1:0]             wr_data_req,

  input  logic                        rd_req,
  input  logic [ADDR_W-1:0]           rd_addr,
  input  logic [LEN_W-1:0]            rd_len,
  output logic                        rd_gnt,
  output logic [DATA_W-1:0]           rd_data,
  output logic                        rd_valid,
  output logic                        rd_last,

  output logic [ADDR_W-1:0]           axi_awaddr,
  output logic [LEN_W-1:0]            axi_awlen,
  output logic [ID_W-1:0]             axi_awuser_id,
  output logic                        axi_awuser_ap,
  output logic                        axi_awvalid,
  input  logic                        axi_awready,

  output logic [DATA_W-1:0]           axi_wdata,
  output logic [STRB_W-1:0]           axi_wstrb,
  input  logic                        axi_wready,
  input  logic                        axi_wusero_last,
  input  logic [ID_W-1:0]             axi_wusero_id,

  output logic [ADDR_W-1:0]           axi_araddr,
  output logic [LEN_W-1:0]            axi_arlen,
  output logic [ID_W-1:0]             axi_aruser_id,
  output logic                        axi_aruser_ap,
  output logic                        axi_arvalid,
  input  logic                        axi_arready,

  input  logic [DATA_W-1:0]           axi_rdata,
  input  logic [ID_W-1:0]             axi_rid,
  input  logic                        axi_rlast,
  input  logic                        axi_rvalid,

  output logic                        busy,
  output logic                        err
);

  localparam int IDX_W = (N_WR > 1) ? $clog2(N_WR) : 1;
  localparam int STK_W = $clog2(RD_MAX + 1);

  arb_state_t        state, state_nx;
  logic [IDX_W-1:0]  g, arb_idx;
  logic [N_WR-1:0]   g_oh, arb_gnt;
  logic [ADDR_W-1:0] lat_addr;
  logic [LEN_W-1:0]  lat_len;
  logic [LEN_W-1:0]  beat_cnt;
  logic [STK_W-1:0]  rd_streak;
  logic              any_wr, go_rd, go_wr;
  logic              w_beat, w_last, r_beat, r_last;
  logic              err_set, wdog_to;

  assign any_wr = |wr_req;
  assign w_beat = (state == WR_DATA) && axi_wready;
  assign w_last = w_beat && axi_wusero_last;
  assign r_beat = (state == RD_DATA) && axi_rvalid;
  assign r_last = r_beat && axi_rlast;

  rr_arbiter #(.N(N_WR), .IDX_W(IDX_W)) u_rr (
    .clk     (clk),
    .rst     (rst),
    .req     (wr_req),
    .advance (go_wr),
    .gnt     (arb_gnt),
    .idx     (arb_idx)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Reads win while writes are idle or the read streak is below RD_MAX.
  always_comb begin
    state_nx = state;
    go_rd    = 1'b0;
    go_wr    = 1'b0;
    unique case (state)
      IDLE: begin
        if (ddr_inited) begin
          if (rd_req && (!any_wr || rd_streak < STK_W'(RD_MAX))) begin
            go_rd    = 1'b1;
            state_nx = RD_ADDR;
          end else if (any_wr) begin
            go_wr    = 1'b1;
            state_nx = WR_ADDR;
          end
        end
      end
      WR_ADDR: if (axi_awready) state_nx = WR_DATA;
      WR_DATA: if (w_last)      state_nx = IDLE;
      RD_ADDR: if (axi_arready) state_nx = RD_DATA;
      RD_DATA: if (r_last)      state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (wdog_to) state_nx = IDLE;
  end

`ifdef DDR_ARB_WDOG_EN
  localparam int WD_W = $clog2(WDOG_TICKS + 1);
  logic [WD_W-1:0] wdog;
  logic            hs;

  assign hs = ((state == WR_ADDR) && axi_awready) || w_beat ||
              ((state == RD_ADDR) && axi_arready) || r_beat;
  assign wdog_to = (state != IDLE) && !hs && (wdog == WD_W'(WDOG_TICKS - 1));

  always_ff @(posedge clk) begin
    if (rst || state == IDLE || hs || wdog_to) wdog <= '0;
    else                                       wdog <= wdog + 1'b1;
  end
`else
  assign wdog_to = 1'b0;
`endif

  assign err_set = (w_last && (beat_cnt != lat_len || axi_wusero_id != ID_W'(g))) ||
                   (r_beat && axi_rid != RD_ID) ||
                   (r_last && beat_cnt != lat_len) ||
                   (axi_rvalid && state != RD_DATA) ||
                   wdog_to;

  always_ff @(posedge clk) begin
    if (rst) begin
      lat_addr  <= '0;
      lat_len   <= '0;
      g         <= '0;
      g_oh      <= '0;
      beat_cnt  <= '0;
      rd_streak <= '0;
      err       <= 1'b0;
    end else begin
      if (go_rd) begin
        lat_addr <= rd_addr;
        lat_len  <= rd_len;
      end else if (go_wr) begin
        lat_addr <= wr_addr[arb_idx];
        lat_len  <= wr_len[arb_idx];
        g        <= arb_idx;
        g_oh     <= arb_gnt;
      end

      if (go_rd || go_wr)     beat_cnt <= '0;
      else if (w_beat || r_beat) beat_cnt <= beat_cnt + 1'b1;

      if (!any_wr || go_wr) rd_streak <= '0;
      else if (go_rd)       rd_streak <= rd_streak + 1'b1;

      if (err_set) err <= 1'b1;
    end
  end

  assign busy          = (state != IDLE);

  assign axi_awvalid   = (state == WR_ADDR);
  assign axi_awaddr    = lat_addr;
  assign axi_awlen     = lat_len;
  assign axi_awuser_id = ID_W'(g);
  assign axi_awuser_ap = 1'b0;

  assign axi_arvalid   = (state == RD_ADDR);
  assign axi_araddr    = lat_addr;
  assign axi_arlen     = lat_len;
  assign axi_aruser_id = axi_arvalid ? RD_ID : '0;
  assign axi_aruser_ap = 1'b0;

  assign wr_gnt        = (axi_awvalid && axi_awready) ? g_oh : '0;
  assign wr_data_req   = w_beat ? g_oh : '0;
  assign axi_wdata     = wr_data[g];
  assign axi_wstrb     = wr_strb[g];

  assign rd_gnt        = axi_arvalid && axi_arready;
  assign rd_data       = axi_rdata;
  assign rd_valid      = r_beat;
  assign rd_last       = (state == RD_DATA) && axi_rlast;

endmodule

// File: doc/ddr_axi_arbiter.md
# ddr_axi_arbiter

Schedules the shared ddr3_32 AXI port between N_WR camera frame-writer burst requesters and one HDMI frame-reader burst requester. It holds one transaction in flight at a time. It drives the AW/W channels, or the AR channel, and routes R data back to the reader. It sits between the per-camera write buffers, the display read buffer and the ddr3_32 controller, in the ddr_clk domain.

## Interface
- N_WR, 2: number of write requesters (1..8)
- RD_MAX, 4: maximum consecutive read grants while any write is pending
- WDOG_TICKS, 4096: watchdog limit in cycles (used only with DDR_ARB_WDOG_EN)

- clk  in  1  DDR controller user clock (phy_clk)
- rst  in  1  synchronous, active-high reset
- ddr_inited  in  1  no grants are issued while low
- wr_req  in  N_WR  burst request, one per writer
- wr_addr  in  N_WR×28  burst start address per writer
- wr_len  in  N_WR×4  beats minus 1 per writer
- wr_data  in  N_WR×256  write data per writer
- wr_strb  in  N_WR×32  byte strobes per writer
- wr_gnt  out  N_WR  one-cycle pulse on the AW handshake
- wr_data_req  out  N_WR  beat accepted; the granted writer advances its data
- rd_req  in  1  read burst request
- rd_addr  in  28  read start address
- rd_len  in  4  read beats minus 1
- rd_gnt  out  1  one-cycle pulse on the AR handshake
- rd_data  out  256  read data
- rd_valid  out  1  read data valid
- rd_last  out  1  last read beat
- axi_awaddr, axi_awlen, axi_awuser_id, axi_awuser_ap, axi_awvalid  out  28/4/4/1/1  write address channel
- axi_awready  in  1  write address accepted
- axi_wdata, axi_wstrb  out  256/32  write data channel
- axi_wready, axi_wusero_last  in  1/1  write beat accepted / last beat
- axi_wusero_id  in  4  ID of the write beat
- axi_araddr, axi_arlen, axi_aruser_id, axi_aruser_ap, axi_arvalid  out  28/4/4/1/1  read address channel
- axi_arready  in  1  read address accepted
- axi_rdata, axi_rid, axi_rlast, axi_rvalid  in  256/4/1/1  read data channel
- busy  out  1  state is not IDLE
- err  out  1  sticky protocol error; cleared only by rst

## Operation
- FSM states: IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_DATA.
- IDLE decision, made only when ddr_inited=1:
  - If rd_req=1 and (no wr_req, or rd_streak<RD_MAX), go to RD_ADDR.
  - Otherwise, if any wr_req=1, go to WR_ADDR with writer g chosen round-robin.
  - The round-robin pointer advances to g+1 on grant.
- rd_streak increments on each read grant. It clears on each write grant and when no write is pending.
- Address, length and g are latched on the IDLE decision cycle. Requesters hold req, addr and len stable until their gnt.
- WR_ADDR:
  - axi_awvalid=1; axi_awuser_id=g; axi_awuser_ap=0.
  - On axi_awready: pulse wr_gnt[g], go to WR_DATA.
- WR_DATA:
  - axi_wdata/axi_wstrb are a combinational mux from writer g.
  - wr_data_req[g]=axi_wready; all other bits are 0.
  - A beat counter counts axi_wready beats.
  - On axi_wready&&axi_wusero_last: go to IDLE.
  - Set err if the last beat's count ≠ latched len, or axi_wusero_id≠g.
- RD_ADDR:
  - axi_arvalid=1; axi_aruser_id=4'hF; axi_aruser_ap=0.
  - On axi_arready: pulse rd_gnt, go to RD_DATA.
- RD_DATA:
  - rd_data=axi_rdata, rd_valid=axi_rvalid, rd_last=axi_rlast, all combinational pass-through.
  - On axi_rvalid&&axi_rlast: go to IDLE.
  - Set err if axi_rid≠4'hF, or the beat count ≠ len at rlast.
- Beat counter width is 4 bits. len=15 gives 16 beats, with no wrap before last.
- rd_valid is forced to 0 outside RD_DATA. Stray R beats in other states set err.

## Timing
- Request sampled in IDLE → awvalid/arvalid asserted the next cycle (1-cycle latency).
- Valid outputs are registered from state. They are held until the ready handshake, and address fields do not change while valid.
- Last beat in cycle n → IDLE in n+1 → next address valid in n+2.
- Reset mid-burst: the next cycle is IDLE. All valids, gnt and data_req go to 0. err, counters, rd_streak and the pointer go to 0. The burst is abandoned.
- Reset values: every output 0, except the mux data outputs, which are don't-care but driven from writer 0 / axi_rdata.
- ddr_inited dropping while busy: the current burst completes, then no further grants are issued.

## Configuration
- DDR_ARB_WDOG_EN defined:
  - A cycle counter restarts on entering any non-IDLE state and on every handshake beat.
  - Reaching WDOG_TICKS sets err, drops all valids and returns to IDLE.
- Undefined: no counter; the FSM waits indefinitely for ready/last.

## Structure
- Package ddr_arb_pkg holds:
  - the state enum;
  - ADDR_W=28, DATA_W=256, STRB_W=32, LEN_W=4, ID_W=4;
  - RD_ID=4'hF.
- Sub-module rr_arbiter: N_WR-way round-robin, request vector in, one-hot grant plus index out, pointer update on an enable input.

## Test plan
- Single writer 0, len=3, awready 2 cycles late, wready every other cycle → awvalid the cycle after req, exactly 4 wr_data_req pulses, IDLE the cycle after last, err=0.
- Both writers requesting continuously → grants alternate 0,1,0,1 over 4 bursts.
- rd_req and wr_req[0] held constantly, RD_MAX=4 → grant order R,R,R,R,W,R,R,R,R,W.
- Read len=7 with axi_rid=4'hF → 8 rd_valid, rd_last on the 8th, rd_gnt one pulse. Repeat with rid=4'h2 → err=1 and sticky.
- rst asserted during beat 2 of a len=7 write → next cycle all outputs 0, busy=0. A new request after reset gets a grant normally.
- DDR_ARB_WDOG_EN with WDOG_TICKS=16, awready never asserted → err=1 and IDLE 16 cycles after WR_ADDR entry. Without the macro, awvalid is still held at cycle 1000.
